// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle between the VGA timing generator, the renderer and the DAC pins.
interface vga_timing_gen_if #(
  parameter int RGB_W = 12,
  parameter int XY_W  = 11
);
  logic [RGB_W-1:0] pix_rgb_in;
  logic [XY_W-1:0]  pix_x;
  logic [XY_W-1:0]  pix_y;
  logic             p_tick;
  logic             video_on;
  logic             line_start;
  logic             frame_start;
  logic [RGB_W-1:0] rgb;
  logic             VGA_HS;
  logic             VGA_VS;

  modport master (
    input  pix_rgb_in,
    output pix_x, pix_y, p_tick, video_on, line_start, frame_start,
    output rgb, VGA_HS, VGA_VS
  );

  modport slave (
    output pix_rgb_in,
    input  pix_x, pix_y, p_tick, video_on, line_start, frame_start,
    input  rgb, VGA_HS, VGA_VS
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable divider, h/v counters, sync/blank alignment pipeline.
// Optional macro VGA_BORDER_EN forces a white one-pixel frame around the active area.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int RGB_W    = 12,
  parameter int XY_W     = 11,
  parameter int PIPE     = 2
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]      DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [XY_W-1:0] H_LAST   = XY_W'(H_TOTAL - 1);
  localparam logic [XY_W-1:0] V_LAST   = XY_W'(V_TOTAL - 1);
  localparam logic [XY_W-1:0] H_ACT    = XY_W'(H_ACTIVE);
  localparam logic [XY_W-1:0] V_ACT    = XY_W'(V_ACTIVE);
  localparam logic [XY_W-1:0] H_SS     = XY_W'(H_ACTIVE + H_FP);
  localparam logic [XY_W-1:0] H_SE     = XY_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XY_W-1:0] V_SS     = XY_W'(V_ACTIVE + V_FP);
  localparam logic [XY_W-1:0] V_SE     = XY_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic            HS_ON    = 1'(HS_POL);
  localparam logic            VS_ON    = 1'(VS_POL);

`ifdef VGA_BORDER_EN
  localparam int SW = 4;
`else
  localparam int SW = 3;
`endif
  // Stage word layout: [0]=video_on, [1]=hs, [2]=vs, [3]=border (when enabled)
  localparam logic [SW-1:0] STAGE_RST = SW'({~VS_ON, ~HS_ON, 1'b0});

  function automatic logic sync_term(input logic [XY_W-1:0] cnt, input logic [XY_W-1:0] lo,
                                     input logic [XY_W-1:0] hi, input logic pol);
    return (cnt >= lo && cnt < hi) ? pol : ~pol;
  endfunction

  logic [3:0]      div_cnt;
  logic            p_tick;
  logic [XY_W-1:0] h_count, v_count, h_next, v_next;
  logic            video_on_q, line_start_q, frame_start_q;
  logic [SW-1:0]   stage_raw, stage_out;
  logic [RGB_W-1:0] rgb_q;
  logic            hs_q, vs_q;

  always_comb begin
    h_next = h_count + XY_W'(1);
    v_next = v_count;
    if (h_count == H_LAST) begin
      h_next = '0;
      v_next = (v_count == V_LAST) ? '0 : v_count + XY_W'(1);
    end
  end

  // Stage p0: divider and counters; video_on is formed from the next count so it stays aligned.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      div_cnt       <= '0;
      p_tick        <= 1'b0;
      h_count       <= '0;
      v_count       <= '0;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt       <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
      p_tick        <= (div_cnt == DIV_LAST);
      line_start_q  <= p_tick && (h_count == H_LAST);
      frame_start_q <= p_tick && (h_count == H_LAST) && (v_count == V_LAST);
      if (p_tick) begin
        h_count    <= h_next;
        v_count    <= v_next;
        video_on_q <= (h_next < H_ACT) && (v_next < V_ACT);
      end
    end
  end

`ifdef VGA_BORDER_EN
  localparam logic [XY_W-1:0] H_ACT_M1 = XY_W'(H_ACTIVE - 1);
  localparam logic [XY_W-1:0] V_ACT_M1 = XY_W'(V_ACTIVE - 1);
  logic border_raw;
  assign border_raw = video_on_q && (h_count == '0 || h_count == H_ACT_M1 ||
                                     v_count == '0 || v_count == V_ACT_M1);
  assign stage_raw  = {border_raw, sync_term(v_count, V_SS, V_SE, VS_ON),
                       sync_term(h_count, H_SS, H_SE, HS_ON), video_on_q};
`else
  assign stage_raw  = {sync_term(v_count, V_SS, V_SE, VS_ON),
                       sync_term(h_count, H_SS, H_SE, HS_ON), video_on_q};
`endif

  // Stages p1..pPIPE: alignment with the renderer's colour latency.
  generate
    if (PIPE == 0) begin : g_nopipe
      assign stage_out = stage_raw;
    end else begin : g_pipe
      logic [SW-1:0] stage_p [PIPE];
      always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIPE; i++) stage_p[i] <= STAGE_RST;
        end else if (p_tick) begin
          stage_p[0] <= stage_raw;
          for (int i = 1; i < PIPE; i++) stage_p[i] <= stage_p[i-1];
        end
      end
      assign stage_out = stage_p[PIPE-1];
    end
  endgenerate

  function automatic logic [RGB_W-1:0] blank_colour(input logic [SW-1:0] st,
                                                    input logic [RGB_W-1:0] pix);
    if (!st[0]) return '0;
`ifdef VGA_BORDER_EN
    if (st[3]) return '1;
`endif
    return pix;
  endfunction

  // Output stage: registered to the DAC pins.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      rgb_q <= '0;
      hs_q  <= ~HS_ON;
      vs_q  <= ~VS_ON;
    end else if (p_tick) begin
      rgb_q <= blank_colour(stage_out, vga.pix_rgb_in);
      hs_q  <= stage_out[1];
      vs_q  <= stage_out[2];
    end
  end

  assign vga.pix_x       = h_count;
  assign vga.pix_y       = v_count;
  assign vga.p_tick      = p_tick;
  assign vga.video_on    = video_on_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.rgb         = rgb_q;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
endmodule
